// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one N-bit valid/ready channel among 4 requesters.
// A grant is held for one burst, which ends on the owner's last beat or after
// MAX_BEATS accepted beats. One IDLE cycle always separates consecutive bursts.
module mux4_rr_arbiter #(
  parameter int unsigned N         = 32,
  parameter int unsigned MAX_BEATS = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [3:0]     in_last,
  input  logic [4*N-1:0] in_data,
  output logic [3:0]     in_ready,
  output logic [3:0]     gnt,
  output logic [1:0]     sel,
  output logic           busy,
  output logic           out_valid,
  output logic [N-1:0]   out_data,
  output logic           out_last,
  input  logic           out_ready
);

  localparam int unsigned CW = $clog2(MAX_BEATS) + 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q;
  logic [1:0]    ptr_q;
  logic [1:0]    sel_q;
  logic [3:0]    gnt_q;
  logic [CW-1:0] cnt_q;

  logic [1:0]    win_d;
  logic [1:0]    scan_idx;
  logic          acc;
  logic          cap_hit;

  // Winner search: scan from the highest offset down so the lowest offset
  // from ptr (i.e. first in round-robin order) is the last one to assign.
  always_comb begin
    win_d    = ptr_q;
    scan_idx = ptr_q;
    for (int unsigned k = 4; k > 0; k--) begin
      scan_idx = ptr_q + 2'(k - 1);
      if (req[scan_idx]) win_d = scan_idx;
    end
  end

  // Datapath mux and handshake, all driven from the registered select.
  always_comb begin
    cap_hit   = (cnt_q == CW'(MAX_BEATS - 1));
    out_valid = (state_q == BUSY) & req[sel_q];
    out_data  = (state_q == BUSY) ? in_data[32'(sel_q)*N +: N] : '0;
    out_last  = out_valid & (in_last[sel_q] | cap_hit);
    acc       = out_valid & out_ready;
    in_ready  = gnt_q & {4{acc}};
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = (state_q == BUSY);

  // Arbitration FSM: grant on the edge after a request is seen in IDLE,
  // hold through stalls, release on the last accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_q   <= 4'b0001 << win_d;
            sel_q   <= win_d;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (acc) begin
            if (out_last) begin
              state_q <= IDLE;
              gnt_q   <= '0;
              ptr_q   <= sel_q + 2'd1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_mux4_rr_arbiter;

  localparam int N    = 32;
  localparam int MAXB = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req, in_last;
  logic [4*N-1:0] in_data;
  logic [3:0]     in_ready, gnt;
  logic [1:0]     sel;
  logic           busy, out_valid, out_last, out_ready;
  logic [N-1:0]   out_data;

  mux4_rr_arbiter #(.N(N), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst(rst), .req(req), .in_last(in_last), .in_data(in_data),
    .in_ready(in_ready), .gnt(gnt), .sel(sel), .busy(busy),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the channel, how many beats it has delivered,
  // and where the next round-robin search starts.
  bit m_busy;
  int m_owner, m_beats, m_ptr;
  bit e_acc, e_last;

  // Last observed DUT values, for scenario-level checks.
  logic [3:0] ob_gnt, ob_rdy;
  logic       ob_last, ob_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    int ev;
    @(negedge clk);
    ev     = m_busy && req[m_owner];
    e_last = ev && (in_last[m_owner] || m_beats == MAXB - 1);
    e_acc  = ev && out_ready;
    chk("busy", 64'(busy), 64'(m_busy));
    chk("gnt", 64'(gnt), m_busy ? 64'(1 << m_owner) : 64'd0);
    if (m_busy) chk("sel", 64'(sel), 64'(m_owner));
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_last", 64'(out_last), 64'(e_last));
    chk("in_ready", 64'(in_ready), e_acc ? 64'(1 << m_owner) : 64'd0);
    if (ev) chk("out_data", 64'(out_data), 64'(in_data[m_owner*N +: N]));
    ob_gnt = gnt; ob_rdy = in_ready; ob_last = out_last; ob_valid = out_valid;
    @(posedge clk);
    if (rst) model_reset();
    else if (!m_busy) begin
      if (req != 4'b0) begin
        for (int k = 3; k >= 0; k--)
          if (req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
        m_busy = 1; m_beats = 0;
      end
    end else if (e_acc) begin
      if (e_last) begin m_busy = 0; m_ptr = (m_owner + 1) % 4; end
      else m_beats++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  initial begin
    int beats, last_at, exp_seq[10];
    logic [N-1:0] held;
    exp_seq = '{0, 1, 0, 2, 0, 4, 0, 8, 0, 1};
    rst = 1'b1; req = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); #1; model_reset();

    // 1: idle after reset with no requests
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // 2: all requesting, single-beat bursts rotate 0,1,2,3,0 with dead cycles
    do_reset();
    req = 4'hF; in_last = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i*N +: N] = 32'h1000_0000 + i;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t2_seq", 64'(ob_gnt), 64'(exp_seq[i]));
    end

    // 3: requester 2 alone, 3-beat burst, then ptr must point at 3
    do_reset();
    req = 4'b0100; in_last = '0; beats = 0; last_at = 0;
    for (int i = 0; i < 8 && last_at == 0; i++) begin
      in_data[2*N +: N] = 32'hA5A5_0001 + beats;
      in_last[2] = (beats == 2);
      step();
      if (ob_rdy[2]) begin
        beats++;
        if (ob_last) last_at = beats;
      end
    end
    chk("t3_last_beat", 64'(last_at), 64'd3);
    req = 4'b1001; in_last = '0;
    step(); step();
    chk("t3_ptr_gnt", 64'(ob_gnt), 64'b1000);

    // 4: endless burst from requester 1 is cut at MAX_BEATS, then 0 wins after wrap
    do_reset();
    req = 4'b0010; in_last = '0; beats = 0; last_at = 0;
    for (int i = 0; i < 20 && last_at == 0; i++) begin
      in_data[1*N +: N] = $urandom;
      step();
      if (ob_rdy[1]) begin
        beats++;
        if (ob_last) last_at = beats;
      end
    end
    chk("t4_forced_len", 64'(last_at), 64'(MAXB));
    req = 4'b0011;
    step(); step();
    chk("t4_wrap_gnt", 64'(ob_gnt), 64'b0001);

    // 5: stall on requester 3; data and grant hold, requester 0 locked out
    do_reset();
    req = 4'b1000; out_ready = 1'b0; in_data[3*N +: N] = 32'hDEAD_BEEF;
    step();
    req = 4'b1001; held = in_data[3*N +: N];
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_hold_gnt", 64'(ob_gnt), 64'b1000);
      chk("t5_stall_data", 64'(out_data), 64'(held));
    end
    out_ready = 1'b1;
    step();
    chk("t5_accept", 64'(ob_rdy), 64'b1000);

    // 6: reset mid-burst abandons it; afterwards ptr=0 so requester 1 beats 3
    do_reset();
    req = 4'b1000; in_last = '0;
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_no_last", 64'(ob_last), 64'd0);
    req = 4'b1010;
    step();
    chk("t6_idle_gnt", 64'(ob_gnt), 64'd0);
    step();
    chk("t6_gnt", 64'(ob_gnt), 64'b0010);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      req       = 4'($urandom);
      in_last   = 4'($urandom) & 4'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(3) != 0);
      rst       = ($urandom_range(60) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
